// File: rtl/reset_sequencer.sv
// reset_sequencer: drives NUM_OUT active-high domain resets that assert
// together and release one by one after a hold period. Reset sources are
// the synchronous reset input and a debounced manual button. The cause of
// the most recent reset event is reported on cause.
// Optional watchdog: define RESET_SEQ_WATCHDOG_EN to reset the domains
// when kick is not pulsed within WDT_CYCLES cycles while running.
module reset_sequencer #(
  parameter int unsigned NUM_OUT         = 3,
  parameter int unsigned HOLD_CYCLES     = 4,
  parameter int unsigned STAGGER_CYCLES  = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 3,
  parameter int unsigned WDT_CYCLES      = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               manual,
  input  logic               kick,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               done,
  output logic [1:0]         cause
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(NUM_OUT + 1);
  localparam int unsigned DCNT_W  = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [1:0] CAUSE_RST = 2'b00;
  localparam logic [1:0] CAUSE_MAN = 2'b01;
`ifdef RESET_SEQ_WATCHDOG_EN
  localparam logic [1:0] CAUSE_WDT = 2'b10;
`endif

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    STAGGER  = 2'd1,
    RUN      = 2'd2,
    MAN_WAIT = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              m_meta;
  logic              m_s;
  logic [DCNT_W-1:0] dcnt;
  logic              man_req;
  logic              wdt_expire;

  // Two-flop synchroniser for the asynchronous button input
  always_ff @(posedge clk) begin
    if (reset) begin
      m_meta <= 1'b0;
      m_s    <= 1'b0;
    end else begin
      m_meta <= manual;
      m_s    <= m_meta;
    end
  end

  // Debounce counter: counts consecutive synchronised-high samples, saturating
  always_ff @(posedge clk) begin
    if (reset || !m_s) begin
      dcnt <= '0;
    end else if (dcnt != DCNT_W'(DEBOUNCE_CYCLES)) begin
      dcnt <= dcnt + DCNT_W'(1);
    end
  end

  // Request fires only on the edge where the counter reaches its terminal value
  assign man_req = m_s && (dcnt == DCNT_W'(DEBOUNCE_CYCLES - 1));

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int unsigned WDT_W = $clog2(WDT_CYCLES);

  logic [WDT_W-1:0] wdt;

  // Watchdog counter runs only in RUN; a kick restarts it
  always_ff @(posedge clk) begin
    if (reset || (state != RUN) || kick) begin
      wdt <= '0;
    end else if (wdt != WDT_W'(WDT_CYCLES - 1)) begin
      wdt <= wdt + WDT_W'(1);
    end
  end

  // A kick on the expiry edge still saves the system
  assign wdt_expire = (state == RUN) && !kick && (wdt == WDT_W'(WDT_CYCLES - 1));
`else
  logic unused_kick;

  assign unused_kick = kick;
  assign wdt_expire  = 1'b0;
`endif

  // Sequencer FSM: priority is reset, then manual request, then watchdog
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      done    <= 1'b0;
      cause   <= CAUSE_RST;
    end else if (man_req) begin
      state   <= MAN_WAIT;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      done    <= 1'b0;
      cause   <= CAUSE_MAN;
    end else if (wdt_expire) begin
      state   <= HOLD;
      cnt     <= '0;
      idx     <= '0;
      rst_out <= '1;
      done    <= 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
      cause   <= CAUSE_WDT;
`endif
    end else begin
      case (state)
        HOLD: begin
          if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
            rst_out[0] <= 1'b0;
            cnt        <= '0;
            idx        <= IDX_W'(1);
            if (NUM_OUT == 1) begin
              state <= RUN;
              done  <= 1'b1;
            end else begin
              state <= STAGGER;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STAGGER: begin
          if (cnt == CNT_W'(STAGGER_CYCLES - 1)) begin
            rst_out[idx] <= 1'b0;
            cnt          <= '0;
            if (idx == IDX_W'(NUM_OUT - 1)) begin
              state <= RUN;
              done  <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          rst_out <= '0;
          done    <= 1'b1;
        end
        MAN_WAIT: begin
          rst_out <= '1;
          done    <= 1'b0;
          if (!m_s) begin
            state <= HOLD;
            cnt   <= '0;
          end
        end
        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
